// File: rtl/lifo_pkg.sv
// Shared definitions for the run-time selectable LIFO/FIFO buffer:
// the mode encoding and the pointer wrap helpers, which do not assume a power-of-two depth.
package lifo_pkg;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_LIFO = 1'b1
  } mode_e;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned ptr_dec(input int unsigned ptr, input int unsigned depth);
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

endpackage

// File: rtl/buffer_mem.sv
// Register array with one synchronous write port and one registered read port.
// A read and a write to the same slot in one cycle returns the old word.
module buffer_mem #(
  parameter  int unsigned DATA_W = 5,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lifo_fifo_buffer.sv
// Parametrised word buffer, run-time selectable as stack or queue, with registered
// status, overflow/underflow pulses, flush, and mode switching (non-empty switch clears).
module lifo_fifo_buffer
  import lifo_pkg::*;
#(
  parameter  int unsigned DATA_W    = 5,
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned AFULL_THR = DEPTH - 1,
  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              flush,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              val,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  mode_e            mode_q, mode_d;
  logic             val_q, val_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             clear;
  logic             is_empty;
  logic             is_full;
  logic             rd_acc;
  logic             wr_acc;
  logic [PTR_W-1:0] wr_inc;
  logic [PTR_W-1:0] wr_dec;
  logic [PTR_W-1:0] rd_inc;

  logic             mem_we;
  logic             mem_re;
  logic [PTR_W-1:0] mem_waddr;
  logic [PTR_W-1:0] mem_raddr;

  always_comb begin
    mode_d      = mode_e'(mode);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    val_d       = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_waddr   = wr_ptr_q;
    mem_raddr   = rd_ptr_q;

    is_empty = (count_q == '0);
    is_full  = (count_q == CNT_W'(DEPTH));
    clear    = flush || ((mode_e'(mode) != mode_q) && !is_empty);
    rd_acc   = read && !is_empty;
    // A pop frees a slot in the same cycle, so a full buffer still accepts read+write.
    wr_acc   = write && (!is_full || rd_acc);

    wr_inc = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
    wr_dec = PTR_W'(ptr_dec(32'(wr_ptr_q), DEPTH));
    rd_inc = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      underflow_d = read && is_empty;
      overflow_d  = write && is_full && !rd_acc;
      val_d       = rd_acc;
      mem_we      = wr_acc;
      mem_re      = rd_acc;
      count_d     = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      if (mode_e'(mode) == MODE_LIFO) begin
        // Stack: read+write swaps the top slot in place, pointer untouched.
        mem_raddr = wr_dec;
        mem_waddr = rd_acc ? wr_dec : wr_ptr_q;
        if (wr_acc && !rd_acc) begin
          wr_ptr_d = wr_inc;
        end else if (rd_acc && !wr_acc) begin
          wr_ptr_d = wr_dec;
        end
      end else begin
        if (wr_acc) begin
          wr_ptr_d = wr_inc;
        end
        if (rd_acc) begin
          rd_ptr_d = rd_inc;
        end
      end
    end

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    afull_d = (32'(count_d) >= AFULL_THR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mode_q      <= MODE_FIFO;
      val_q       <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      val_q       <= val_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clock),
    .rst   (reset),
    .clr   (clear),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (datain),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (dataout)
  );

  assign val       = val_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign afull     = afull_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Directed bench: expected pops go into per-instance queues, monitors compare on each val pulse.
// Instance a: DEPTH=2 (LIFO/FIFO, errors, flush, reset); instance b: DEPTH=3, AFULL_THR=2 wrap test.
module tb_lifo_fifo_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic       rst_a, mode_a, flush_a, write_a, read_a;
  logic [4:0] din_a, dout_a;
  logic       val_a, full_a, empty_a, afull_a, ovf_a, udf_a;
  logic [1:0] cnt_a;

  logic       rst_b, mode_b, flush_b, write_b, read_b;
  logic [4:0] din_b, dout_b;
  logic       val_b, full_b, empty_b, afull_b, ovf_b, udf_b;
  logic [1:0] cnt_b;

  logic [4:0] qa[$];
  logic [4:0] qb[$];

  lifo_fifo_buffer #(.DATA_W(5), .DEPTH(2)) dut_a (
    .clock(clk), .reset(rst_a), .mode(mode_a), .flush(flush_a), .write(write_a), .read(read_a),
    .datain(din_a), .dataout(dout_a), .val(val_a), .full(full_a), .empty(empty_a),
    .afull(afull_a), .count(cnt_a), .overflow(ovf_a), .underflow(udf_a)
  );

  lifo_fifo_buffer #(.DATA_W(5), .DEPTH(3), .AFULL_THR(2)) dut_b (
    .clock(clk), .reset(rst_b), .mode(mode_b), .flush(flush_b), .write(write_b), .read(read_b),
    .datain(din_b), .dataout(dout_b), .val(val_b), .full(full_b), .empty(empty_b),
    .afull(afull_b), .count(cnt_b), .overflow(ovf_b), .underflow(udf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (val_a === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_val", 32'(val_a), 32'd0);
      end else begin
        chk("a_dataout", 32'(dout_a), 32'(qa.pop_front()));
      end
    end
    if (val_b === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_val", 32'(val_b), 32'd0);
      end else begin
        chk("b_dataout", 32'(dout_b), 32'(qb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; results are sampled there too.
  task automatic step_a(input logic r, input logic m, input logic f, input logic w,
                        input logic rd, input logic [4:0] d);
    rst_a = r; mode_a = m; flush_a = f; write_a = w; read_a = rd; din_a = d;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic w, input logic rd, input logic [4:0] d);
    rst_b = 1'b0; mode_b = 1'b0; flush_b = 1'b0; write_b = w; read_b = rd; din_b = d;
    @(posedge clk); #1;
  endtask

  task automatic chk_status_a(input string tag, input int cnt, input logic f, input logic e,
                              input logic af);
    chk({tag, "_count"}, 32'(cnt_a), 32'(cnt));
    chk({tag, "_full"},  32'(full_a), 32'(f));
    chk({tag, "_empty"}, 32'(empty_a), 32'(e));
    chk({tag, "_afull"}, 32'(afull_a), 32'(af));
  endtask

  task automatic chk_reset_a(input string tag);
    chk_status_a(tag, 0, 1'b0, 1'b1, 1'b0);
    chk({tag, "_val"},  32'(val_a), 32'd0);
    chk({tag, "_dout"}, 32'(dout_a), 32'd0);
    chk({tag, "_ovf"},  32'(ovf_a), 32'd0);
    chk({tag, "_udf"},  32'(udf_a), 32'd0);
  endtask

  initial begin
    rst_b = 1'b1; mode_b = 1'b0; flush_b = 1'b0; write_b = 1'b0; read_b = 1'b0; din_b = '0;
    @(posedge clk); #1;
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_reset_a("reset");
    chk("b_reset_empty", 32'(empty_b), 32'd1);

    // LIFO push/pop order
    step_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10011);
    chk_status_a("lifo_push1", 1, 1'b0, 1'b0, 1'b1);
    step_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11001);
    chk_status_a("lifo_push2", 2, 1'b1, 1'b0, 1'b1);
    qa.push_back(5'b11001);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    qa.push_back(5'b10011);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_status_a("lifo_drained", 0, 1'b0, 1'b1, 1'b0);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("lifo_idle_val", 32'(val_a), 32'd0);
    chk("lifo_hold_dout", 32'(dout_a), 32'(5'b10011));

    // LIFO full, read+write held three cycles
    step_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10011);
    step_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11001);
    qa.push_back(5'b11001);
    qa.push_back(5'b10000);
    qa.push_back(5'b10000);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b10000);
      chk("lifo_swap_count", 32'(cnt_a), 32'd2);
      chk("lifo_swap_ovf", 32'(ovf_a), 32'd0);
    end

    // mode toggle while holding two words acts as flush
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_reset_a("mode_toggle");

    // FIFO order, overflow
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10011);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11001);
    chk_status_a("fifo_full", 2, 1'b1, 1'b0, 1'b1);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00111);
    chk("fifo_ovf", 32'(ovf_a), 32'd1);
    chk("fifo_ovf_count", 32'(cnt_a), 32'd2);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("fifo_ovf_pulse", 32'(ovf_a), 32'd0);
    qa.push_back(5'b10011);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    qa.push_back(5'b11001);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

    // underflow on empty, then read+write on empty
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    chk("udf_pulse", 32'(udf_a), 32'd1);
    chk("udf_val", 32'(val_a), 32'd0);
    chk("udf_count", 32'(cnt_a), 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b01010);
    chk("rw_empty_udf", 32'(udf_a), 32'd1);
    chk("rw_empty_val", 32'(val_a), 32'd0);
    chk("rw_empty_count", 32'(cnt_a), 32'd1);

    // FIFO full read+write: head leaves, new word at tail
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001);
    qa.push_back(5'b01010);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111);
    chk_status_a("fifo_rw_full", 2, 1'b1, 1'b0, 1'b1);
    chk("fifo_rw_ovf", 32'(ovf_a), 32'd0);
    qa.push_back(5'b00001);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    qa.push_back(5'b11111);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

    // flush mid-stream, with read+write asserted
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00010);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00011);
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00100);
    chk_reset_a("flush");

    // reset mid-stream
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00100);
    qa.push_back(5'b00100);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00101);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00110);
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    chk_reset_a("mid_reset");
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    // DEPTH=3 FIFO: wrap crossing, afull at count 2
    step_b(1'b1, 1'b0, 5'd1);
    chk("b_push1_afull", 32'(afull_b), 32'd0);
    step_b(1'b1, 1'b0, 5'd2);
    chk("b_push2_afull", 32'(afull_b), 32'd1);
    chk("b_push2_full", 32'(full_b), 32'd0);
    for (int i = 0; i < 5; i++) begin
      qb.push_back(5'(i + 1));
      step_b(1'b1, 1'b1, 5'(i + 3));
      chk("b_round_count", 32'(cnt_b), 32'd2);
    end
    step_b(1'b1, 1'b0, 5'd8);
    chk("b_full", 32'(full_b), 32'd1);
    chk("b_full_count", 32'(cnt_b), 32'd3);
    qb.push_back(5'd6);
    step_b(1'b0, 1'b1, 5'd0);
    chk("b_pop1_afull", 32'(afull_b), 32'd1);
    qb.push_back(5'd7);
    step_b(1'b0, 1'b1, 5'd0);
    chk("b_pop2_afull", 32'(afull_b), 32'd0);
    qb.push_back(5'd8);
    step_b(1'b0, 1'b1, 5'd0);
    chk("b_drained_empty", 32'(empty_b), 32'd1);
    step_b(1'b0, 1'b0, 5'd0);
    step_b(1'b0, 1'b0, 5'd0);

    chk("a_pops_outstanding", 32'(qa.size()), 32'd0);
    chk("b_pops_outstanding", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
